// File: rtl/segment_transition_ctrl_pkg.sv
// Shared encodings for segment transition control, reused by the modulation and STM controllers.
package segment_transition_ctrl_pkg;

    localparam logic [7:0]  TRANSITION_MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0]  TRANSITION_MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0]  TRANSITION_MODE_GPIO      = 8'h02;
    localparam logic [7:0]  TRANSITION_MODE_IMMEDIATE = 8'hFF;

    localparam logic [15:0] REP_INF = 16'hFFFF;

    typedef enum logic [1:0] {
        StPlayInf,
        StPlayFin,
        StStopped,
        StWait
    } trans_state_e;

    function automatic logic mode_is_valid(input logic [7:0] mode);
        return (mode == TRANSITION_MODE_SYNC_IDX) || (mode == TRANSITION_MODE_SYS_TIME) ||
               (mode == TRANSITION_MODE_GPIO)     || (mode == TRANSITION_MODE_IMMEDIATE);
    endfunction

endpackage

// File: rtl/gpio_edge_sync.sv
// Two-flop synchronizer for asynchronous trigger pins with a one-cycle rising-edge pulse.
module gpio_edge_sync #(
    parameter int unsigned Width = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [Width-1:0] i_async,
    output logic [Width-1:0] o_rise
);

    logic [Width-1:0] r_meta;
    logic [Width-1:0] r_sync;
    logic [Width-1:0] r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/segment_transition_ctrl.sv
// Selects the active read segment and schedules switches on index wrap, time, GPIO or at once,
// while counting loops of finite segments.
module segment_transition_ctrl
    import segment_transition_ctrl_pkg::*;
#(
    parameter logic [15:0] REP_INF = segment_transition_ctrl_pkg::REP_INF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_update,
    input  logic             i_req_rd_segment,
    input  logic [7:0]       i_transition_mode,
    input  logic [63:0]      i_transition_value,
    input  logic [1:0][15:0] i_rep,
    input  logic [63:0]      i_sys_time,
    input  logic             i_loop_end,
    input  logic [3:0]       i_gpio_in,
    output logic             o_segment,
    output logic             o_seg_start,
    output logic             o_stop,
    output logic             o_busy
);

    trans_state_e r_state;
    logic         r_segment;
    logic         r_seg_start;
    logic         r_stop;
    logic         r_fin;
    logic [15:0]  r_cnt;
    logic         r_pend_seg;
    logic [7:0]   r_pend_mode;
    logic [63:0]  r_pend_value;

    trans_state_e w_state_nxt;
    logic         w_segment_nxt;
    logic         w_seg_start_nxt;
    logic         w_stop_nxt;
    logic         w_fin_nxt;
    logic [15:0]  w_cnt_nxt;
    logic         w_pend_seg_nxt;
    logic [7:0]   w_pend_mode_nxt;
    logic [63:0]  w_pend_value_nxt;

    logic [3:0]   w_rise;
    logic         w_upd_imm;
    logic         w_upd_wait;
    logic         w_trig_cond;
    logic         w_trigger;
    logic         w_sw_en;
    logic         w_sw_seg;
    logic         w_sw_fin;

    gpio_edge_sync #(
        .Width (4)
    ) u_gpio_edge_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_gpio_in),
        .o_rise  (w_rise)
    );

    always_comb begin
        w_upd_imm  = i_update && (i_transition_mode == TRANSITION_MODE_IMMEDIATE);
        w_upd_wait = i_update && mode_is_valid(i_transition_mode) && !w_upd_imm;

        // A stopped segment never produces another LOOP_END, so SYNC_IDX fires on STOP instead.
        unique case (r_pend_mode)
            TRANSITION_MODE_SYNC_IDX: w_trig_cond = i_loop_end || r_stop;
            TRANSITION_MODE_SYS_TIME: w_trig_cond = (i_sys_time >= r_pend_value);
            TRANSITION_MODE_GPIO:     w_trig_cond = w_rise[r_pend_value[1:0]];
            default:                  w_trig_cond = 1'b0;
        endcase

        w_trigger = (r_state == StWait) && !w_upd_imm && !w_upd_wait && w_trig_cond;
        w_sw_en   = w_upd_imm || w_trigger;
        w_sw_seg  = w_upd_imm ? i_req_rd_segment : r_pend_seg;
        w_sw_fin  = (i_rep[w_sw_seg] != REP_INF);
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_segment_nxt    = r_segment;
        w_seg_start_nxt  = 1'b0;
        w_stop_nxt       = r_stop;
        w_fin_nxt        = r_fin;
        w_cnt_nxt        = r_cnt;
        w_pend_seg_nxt   = r_pend_seg;
        w_pend_mode_nxt  = r_pend_mode;
        w_pend_value_nxt = r_pend_value;

        // Loop counting continues in WAIT; only a switch resets it.
        if (r_fin && !r_stop && i_loop_end) begin
            if (r_cnt == i_rep[r_segment]) begin
                w_stop_nxt = 1'b1;
                if (r_state != StWait) begin
                    w_state_nxt = StStopped;
                end
            end else begin
                w_cnt_nxt = r_cnt + 16'd1;
            end
        end

        if (w_sw_en) begin
            w_segment_nxt    = w_sw_seg;
            w_seg_start_nxt  = 1'b1;
            w_stop_nxt       = 1'b0;
            w_cnt_nxt        = '0;
            w_fin_nxt        = w_sw_fin;
            w_state_nxt      = w_sw_fin ? StPlayFin : StPlayInf;
            w_pend_seg_nxt   = 1'b0;
            w_pend_mode_nxt  = '0;
            w_pend_value_nxt = '0;
        end else if (w_upd_wait) begin
            w_state_nxt      = StWait;
            w_pend_seg_nxt   = i_req_rd_segment;
            w_pend_mode_nxt  = i_transition_mode;
            w_pend_value_nxt = i_transition_value;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StPlayInf;
            r_segment    <= 1'b0;
            r_seg_start  <= 1'b0;
            r_stop       <= 1'b0;
            r_fin        <= 1'b0;
            r_cnt        <= '0;
            r_pend_seg   <= 1'b0;
            r_pend_mode  <= '0;
            r_pend_value <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_segment    <= w_segment_nxt;
            r_seg_start  <= w_seg_start_nxt;
            r_stop       <= w_stop_nxt;
            r_fin        <= w_fin_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pend_seg   <= w_pend_seg_nxt;
            r_pend_mode  <= w_pend_mode_nxt;
            r_pend_value <= w_pend_value_nxt;
        end
    end

    assign o_segment   = r_segment;
    assign o_seg_start = r_seg_start;
    assign o_stop      = r_stop;
    assign o_busy      = (r_state == StWait);

endmodule

// File: tb/tb_segment_transition_ctrl.sv
// Bench for segment_transition_ctrl: directed vector table, corner-case sequences and a
// randomized run against a request/loop-count reference model.
module tb_segment_transition_ctrl;
    import segment_transition_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             update = 1'b0;
    logic             req_seg = 1'b0;
    logic [7:0]       mode = 8'h00;
    logic [63:0]      tval = 64'd0;
    logic [1:0][15:0] rep;
    logic [63:0]      sys_time = 64'h0000_00FF_FFFF_FF00;
    logic             loop_end = 1'b0;
    logic [3:0]       gpio = 4'h0;
    logic             o_segment, o_seg_start, o_stop, o_busy;

    always #5 clk = ~clk;

    segment_transition_ctrl dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_update           (update),
        .i_req_rd_segment   (req_seg),
        .i_transition_mode  (mode),
        .i_transition_value (tval),
        .i_rep              (rep),
        .i_sys_time         (sys_time),
        .i_loop_end         (loop_end),
        .i_gpio_in          (gpio),
        .o_segment          (o_segment),
        .o_seg_start        (o_seg_start),
        .o_stop             (o_stop),
        .o_busy             (o_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: active segment, completed loops, and at most one pending request.
    logic        m_seg, m_start, m_stop, m_busy, m_fin, m_pseg;
    logic [7:0]  m_pmode;
    logic [63:0] m_pval;
    int          m_loops;
    logic [3:0]  h0, h1, h2;  // pin values seen 1, 2 and 3 edges ago

    task automatic m_switch(input logic s);
        m_seg   = s;
        m_start = 1'b1;
        m_busy  = 1'b0;
        m_stop  = 1'b0;
        m_loops = 0;
        m_fin   = (rep[s] != REP_INF);
    endtask

    task automatic model_edge();
        logic       ok, cond, trig;
        logic [3:0] rise;
        if (rst) begin
            m_seg = 0; m_start = 0; m_stop = 0; m_busy = 0; m_fin = 0; m_pseg = 0;
            m_pmode = 0; m_pval = 0; m_loops = 0; h0 = 0; h1 = 0; h2 = 0;
            return;
        end
        rise = h1 & ~h2;
        ok = update && (mode == 8'h00 || mode == 8'h01 || mode == 8'h02 || mode == 8'hFF);
        case (m_pmode)
            8'h00:   cond = loop_end || m_stop;
            8'h01:   cond = (sys_time >= m_pval);
            8'h02:   cond = rise[m_pval[1:0]];
            default: cond = 1'b0;
        endcase
        trig = m_busy && !ok && cond;
        m_start = 1'b0;
        if (m_fin && !m_stop && loop_end) begin
            m_loops++;
            if (m_loops > int'(rep[m_seg])) m_stop = 1'b1;
        end
        if (update && mode == 8'hFF) begin
            m_switch(req_seg);
        end else if (ok) begin
            m_busy = 1'b1; m_pseg = req_seg; m_pmode = mode; m_pval = tval;
        end else if (trig) begin
            m_switch(m_pseg);
        end
        h2 = h1; h1 = h0; h0 = gpio;
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: seg/start/stop/busy got %b expected %b at %0t", name, got, exp,
                     $time);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input string name);
        @(posedge clk);
        #1;
        model_edge();
        check(name, {o_segment, o_seg_start, o_stop, o_busy}, {m_seg, m_start, m_stop, m_busy});
        sys_time = sys_time + 64'd1;
    endtask

    task automatic drive(input logic r, input logic u, input logic s, input logic [7:0] md,
                         input logic [63:0] v, input logic le);
        rst = r; update = u; req_seg = s; mode = md; tval = v; loop_end = le;
    endtask

    function automatic logic [3:0] outs();
        return {o_segment, o_seg_start, o_stop, o_busy};
    endfunction

    typedef struct {
        logic        r, u, s;
        logic [7:0]  md;
        logic [63:0] v;
        logic        le;
        logic [3:0]  exp;  // {segment, seg_start, stop, busy} after the edge
    } vec_t;

    vec_t tbl[22];

    initial begin
        logic        found;
        int          n;
        logic [63:0] tv, t_sw;

        rep = {16'd2, REP_INF};
        tbl[0]  = '{1, 0, 0, 8'h00, 64'd0, 0, 4'b0000};
        tbl[1]  = '{0, 1, 1, 8'hFF, 64'd0, 0, 4'b1100};
        tbl[2]  = '{0, 0, 0, 8'h00, 64'd0, 0, 4'b1000};
        tbl[3]  = '{0, 0, 0, 8'h00, 64'd0, 1, 4'b1000};
        tbl[4]  = '{0, 0, 0, 8'h00, 64'd0, 1, 4'b1000};
        tbl[5]  = '{0, 0, 0, 8'h00, 64'd0, 1, 4'b1010};
        tbl[6]  = '{0, 0, 0, 8'h00, 64'd0, 0, 4'b1010};
        tbl[7]  = '{0, 1, 0, 8'h00, 64'd0, 0, 4'b1011};
        tbl[8]  = '{0, 0, 0, 8'h00, 64'd0, 0, 4'b0100};
        tbl[9]  = '{0, 0, 0, 8'h00, 64'd0, 0, 4'b0000};
        tbl[10] = '{0, 0, 0, 8'h00, 64'd0, 1, 4'b0000};
        tbl[11] = '{0, 1, 1, 8'h01, 64'd0, 0, 4'b0001};
        tbl[12] = '{0, 0, 0, 8'h00, 64'd0, 0, 4'b1100};
        tbl[13] = '{0, 1, 0, 8'h07, 64'd0, 0, 4'b1000};
        tbl[14] = '{0, 1, 1, 8'h00, 64'd0, 0, 4'b1001};
        tbl[15] = '{0, 0, 0, 8'h00, 64'd0, 1, 4'b1100};
        tbl[16] = '{0, 0, 0, 8'h00, 64'd0, 1, 4'b1000};
        tbl[17] = '{0, 1, 0, 8'h02, 64'd3, 1, 4'b1001};
        tbl[18] = '{0, 0, 0, 8'h00, 64'd0, 1, 4'b1011};
        tbl[19] = '{0, 0, 0, 8'h00, 64'd0, 0, 4'b1011};
        tbl[20] = '{0, 1, 0, 8'h00, 64'd0, 0, 4'b1011};
        tbl[21] = '{0, 0, 0, 8'h00, 64'd0, 0, 4'b0100};

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].r, tbl[i].u, tbl[i].s, tbl[i].md, tbl[i].v, tbl[i].le);
            step("table_model");
            check($sformatf("table_row%0d", i), outs(), tbl[i].exp);
        end

        // Immediate switch: one-cycle latency and a single SEG_START pulse.
        drive(1, 0, 0, 8'h00, 64'd0, 0); step("imm_reset");
        check("imm_reset_state", outs(), 4'b0000);
        drive(0, 1, 1, 8'hFF, 64'd0, 0); step("imm_switch");
        check("imm_switch", outs(), 4'b1100);
        drive(0, 0, 0, 8'h00, 64'd0, 0); step("imm_after");
        check("imm_pulse_end", outs(), 4'b1000);

        // System-time trigger: switch visible the cycle after SYS_TIME equals the value.
        tv = sys_time + 64'd100;
        drive(0, 1, 0, 8'h01, tv, 0); step("time_latch");
        drive(0, 0, 0, 8'h00, 64'd0, 0);
        found = 1'b0;
        t_sw  = '0;
        for (int k = 0; k < 200 && !found; k++) begin
            step("time_wait");
            if (o_seg_start) begin
                found = 1'b1;
                t_sw  = sys_time - 64'd1;
            end
        end
        check_val("time_switch_at", t_sw, tv);

        // GPIO trigger: non-selected pin ignored, selected pin edge switches within 4 cycles.
        drive(0, 1, 1, 8'h02, 64'd2, 0); step("gpio_latch");
        drive(0, 0, 0, 8'h00, 64'd0, 0);
        gpio = 4'b0010; repeat (4) step("gpio_other_hi");
        gpio = 4'b0000; repeat (3) step("gpio_other_lo");
        check("gpio_still_busy", outs(), 4'b0001);
        gpio  = 4'b0100;
        found = 1'b0;
        n     = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            step("gpio_wait");
            n++;
            if (o_seg_start) found = 1'b1;
        end
        check_val("gpio_latency_ok", {63'd0, found && n <= 4}, 64'd1);
        gpio = 4'b0000;

        // Replacing a pending SYNC_IDX request: only the second one fires.
        drive(0, 1, 1, 8'hFF, 64'd0, 0); step("repl_imm");
        drive(0, 1, 1, 8'h00, 64'd0, 0); step("repl_first");
        drive(0, 1, 0, 8'h00, 64'd0, 0); step("repl_second");
        drive(0, 0, 0, 8'h00, 64'd0, 0); repeat (3) step("repl_idle");
        drive(0, 0, 0, 8'h00, 64'd0, 1); step("repl_loop_end");
        check("repl_fires_second", outs(), 4'b0100);
        drive(0, 0, 0, 8'h00, 64'd0, 1); step("repl_loop_end2");
        check("repl_no_first", outs(), 4'b0000);

        // Reset during WAIT drops the request for good.
        drive(0, 1, 1, 8'h00, 64'd0, 0); step("rstwait_latch");
        check("rstwait_busy", outs(), 4'b0001);
        drive(1, 0, 0, 8'h00, 64'd0, 0); step("rstwait_reset");
        check("rstwait_cleared", outs(), 4'b0000);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 8'h00, 64'd0, 1); step("rstwait_le");
            n += int'(o_seg_start);
            drive(0, 0, 0, 8'h00, 64'd0, 0); step("rstwait_idle");
            n += int'(o_seg_start);
        end
        check_val("rstwait_no_start", 64'(n), 64'd0);

        // Randomized run, REP reselected only across resets.
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < 2; s++) begin
                case ($urandom_range(0, 4))
                    0: rep[s] = 16'd0;
                    1: rep[s] = 16'd1;
                    2: rep[s] = 16'd2;
                    3: rep[s] = 16'd3;
                    default: rep[s] = REP_INF;
                endcase
            end
            drive(1, 0, 0, 8'h00, 64'd0, 0); step("rand_reset");
            for (int k = 0; k < 600; k++) begin
                update  = ($urandom_range(0, 7) == 0);
                req_seg = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 5))
                    0: mode = 8'h00;
                    1: mode = 8'h01;
                    2: mode = 8'h02;
                    3: mode = 8'hFF;
                    4: mode = 8'($urandom);
                    default: mode = 8'h00;
                endcase
                if (mode == 8'h01) tval = sys_time + 64'($urandom_range(0, 30)) - 64'd5;
                else tval = {$urandom, $urandom};
                loop_end = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 3) == 0) gpio = 4'($urandom);
                rst = ($urandom_range(0, 299) == 0);
                step("random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/segment_transition_ctrl.md
SEGMENT_TRANSITION_CTRL -- requirements
Module: segment_transition_ctrl

Interface
REQ-001 Parameter: REP_INF, 16'hFFFF, repetition value meaning loop forever.
REQ-002 CLK  in  1  system clock; the block has one clock and reset is synchronous and active-high.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 UPDATE  in  1  one-cycle pulse: latch a new transition request.
REQ-005 REQ_RD_SEGMENT  in  1  requested segment (0/1), sampled on UPDATE.
REQ-006 TRANSITION_MODE  in  8  trigger mode, sampled on UPDATE.
REQ-007 TRANSITION_VALUE  in  64  mode argument (system time, or GPIO index in [1:0]), sampled on UPDATE.
REQ-008 REP  in  16x2  repetition count per segment, from mod_settings_t.
REQ-009 SYS_TIME  in  64  free-running system time.
REQ-010 LOOP_END  in  1  one-cycle pulse from the index generator when the current segment wraps to index 0.
REQ-011 GPIO_IN  in  4  asynchronous external trigger inputs.
REQ-012 SEGMENT  out  1  registered active read segment.
REQ-013 SEG_START  out  1  one-cycle pulse on every switch; it restarts the index generator.
REQ-014 STOP  out  1  high while a finite segment is exhausted; output holds its last sample.
REQ-015 BUSY  out  1  high while a request is pending (WAIT state).

Function
REQ-016 Modes: 8'h00 SYNC_IDX (next LOOP_END), 8'h01 SYS_TIME (SYS_TIME >= TRANSITION_VALUE, unsigned 64-bit), 8'h02 GPIO (rising edge of GPIO_IN[TRANSITION_VALUE[1:0]]), 8'hFF IMMEDIATE; any other value is discarded with no state change.
REQ-017 States: PLAY_INF, PLAY_FIN, STOPPED, WAIT.
REQ-018 UPDATE with IMMEDIATE in any state: SEGMENT and SEG_START update in the following cycle, with no WAIT.
REQ-019 UPDATE with another valid mode in any state: latch segment, mode and value; go to WAIT; BUSY=1 from the next cycle.
REQ-020 A new UPDATE in WAIT replaces the pending request; the old request never fires.
REQ-021 Trigger detected in cycle n: SEGMENT=pending segment, SEG_START=1, BUSY=0 in cycle n+1; loop counter cleared; STOP=0.
REQ-022 Next state after a switch: PLAY_INF if REP[new]==REP_INF, else PLAY_FIN.
REQ-023 PLAY_FIN: count LOOP_END pulses in a 16-bit counter; when LOOP_END arrives with count==REP[SEGMENT], go to STOPPED with STOP=1 next cycle (REP=0 gives one loop).
REQ-024 SYNC_IDX pending while STOPPED or entered from STOPPED: trigger next cycle, since no LOOP_END will arrive.
REQ-025 SYS_TIME already past at latch: trigger in the first WAIT cycle.
REQ-026 GPIO_IN passes a 2-FF synchronizer plus edge detect; an edge at the pin is detected within 3 cycles.
REQ-027 Simultaneous UPDATE and trigger: UPDATE wins; the old request is dropped.
REQ-028 Simultaneous LOOP_END and a SYNC_IDX trigger in WAIT: switch; the loop count is not incremented.
REQ-029 Requesting the already-active segment is legal: the block switches and SEG_START pulses.
REQ-030 In WAIT, the counter keeps running on the current segment; reaching REP enters STOPPED behaviour (STOP=1) while staying pending.

Reset
REQ-031 RST (synchronous): SEGMENT=0, SEG_START=0, STOP=0, BUSY=0, state PLAY_INF, counter 0, pending cleared, synchronizer flops 0.
REQ-032 RST mid-WAIT discards the pending request; no SEG_START is issued.

Structure
REQ-033 Mode encodings (TRANSITION_MODE_SYNC_IDX/SYS_TIME/GPIO/IMMEDIATE) and REP_INF shall live in the shared params package, reused by the STM instance.
REQ-034 One sub-module, gpio_edge_sync (2-FF sync + rising-edge pulse, 4 bits); the block is instantiated once each for modulation and STM.

Verification
REQ-035 Reset, then UPDATE seg=1 mode=FF -> SEGMENT=1 and SEG_START pulse exactly 1 cycle after UPDATE.
REQ-036 REP[1]=2, seg 1 active, 3 LOOP_END pulses -> STOP=1 the cycle after the third pulse; no STOP after the second.
REQ-037 Mode=01, value=SYS_TIME+100 -> BUSY=1 until SYS_TIME reaches value; SEGMENT switches the cycle after equality.
REQ-038 Mode=02, value=2; GPIO_IN[1] toggled (ignored), then GPIO_IN[2] rises -> switch within 4 cycles of the pin edge.
REQ-039 Mode=00 pending, second UPDATE (seg 0, mode=00) -> only the second request fires at the next LOOP_END.
REQ-040 RST asserted during WAIT -> SEGMENT=0, BUSY=0, and no SEG_START over the following 10 LOOP_END pulses.
